// File: rtl/display_scan_7seg.sv
// Four-digit multiplexed common-anode 7-segment scanner, stepped by DivCLK rising edges.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits 3..1.
module display_scan_7seg #(
  parameter int unsigned DWELL_TICKS = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        DivCLK,
  input  logic        Enable,
  input  logic [15:0] Value,
  input  logic [3:0]  DP,
  output logic [3:0]  Anodes,
  output logic [6:0]  Segments,
  output logic        DPout
);

  localparam logic [7:0] LP_DWELL_LAST = 8'(DWELL_TICKS - 1);

  logic        r_s1, r_s2, r_s3;
  logic        r_en_d;
  logic [7:0]  r_dwell;
  logic [1:0]  r_idx;
  logic [15:0] r_shadow_val;
  logic [3:0]  r_shadow_dp;
  logic [3:0]  r_anodes;
  logic [6:0]  r_segments;
  logic        r_dpout;

  logic        w_tick;
  logic        w_count;
  logic        w_advance;
  logic        w_snap;
  logic [3:0]  w_nibble;
  logic        w_dp;
  logic [6:0]  w_glyph;
  logic        w_blank;

  // Edge detector on the synchronised DivCLK; it is data, never a clock.
  assign w_tick    = r_s2 & ~r_s3;
  assign w_count   = w_tick & Enable;
  assign w_advance = w_count & (r_dwell == LP_DWELL_LAST);
  assign w_snap    = (Enable & ~r_en_d) | (w_advance & (r_idx == 2'd3));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= DivCLK;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_en_d  <= 1'b0;
      r_dwell <= '0;
      r_idx   <= '0;
    end else begin
      r_en_d <= Enable;
      if (w_advance) begin
        r_dwell <= '0;
        r_idx   <= r_idx + 2'd1;
      end else if (w_count) begin
        r_dwell <= r_dwell + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
    end else if (w_snap) begin
      r_shadow_val <= Value;
      r_shadow_dp  <= DP;
    end
  end

  always_comb begin
    w_nibble = r_shadow_val[3:0];
    w_dp     = r_shadow_dp[0];
    case (r_idx)
      2'd0: begin w_nibble = r_shadow_val[3:0];   w_dp = r_shadow_dp[0]; end
      2'd1: begin w_nibble = r_shadow_val[7:4];   w_dp = r_shadow_dp[1]; end
      2'd2: begin w_nibble = r_shadow_val[11:8];  w_dp = r_shadow_dp[2]; end
      2'd3: begin w_nibble = r_shadow_val[15:12]; w_dp = r_shadow_dp[3]; end
      default: begin w_nibble = r_shadow_val[3:0]; w_dp = r_shadow_dp[0]; end
    endcase
  end

  always_comb begin
    w_glyph = 7'h7F;
    case (w_nibble)
      4'h0: w_glyph = 7'b1000000;
      4'h1: w_glyph = 7'b1111001;
      4'h2: w_glyph = 7'b0100100;
      4'h3: w_glyph = 7'b0110000;
      4'h4: w_glyph = 7'b0011001;
      4'h5: w_glyph = 7'b0010010;
      4'h6: w_glyph = 7'b0000010;
      4'h7: w_glyph = 7'b1111000;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0010000;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b0000011;
      4'hC: w_glyph = 7'b1000110;
      4'hD: w_glyph = 7'b0100001;
      4'hE: w_glyph = 7'b0000110;
      4'hF: w_glyph = 7'b0001110;
      default: w_glyph = 7'h7F;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank only if it and every more-significant nibble are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd1: w_blank = (r_shadow_val[15:4]  == 12'h000);
      2'd2: w_blank = (r_shadow_val[15:8]  == 8'h00);
      2'd3: w_blank = (r_shadow_val[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  // Dark on the Enable-rise cycle so the first lit frame comes from the fresh snapshot.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_anodes   <= '1;
      r_segments <= '1;
      r_dpout    <= 1'b1;
    end else if (Enable && r_en_d) begin
      r_anodes   <= ~(4'b0001 << r_idx);
      r_segments <= w_blank ? 7'h7F : w_glyph;
      r_dpout    <= ~w_dp;
    end else begin
      r_anodes   <= '1;
      r_segments <= '1;
      r_dpout    <= 1'b1;
    end
  end

  assign Anodes   = r_anodes;
  assign Segments = r_segments;
  assign DPout    = r_dpout;

endmodule

// File: tb/tb_display_scan_7seg.sv
// Self-checking bench for display_scan_7seg: two instances (dwell 1 and dwell 3) against a tick-count model.
module tb_display_scan_7seg;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        DivCLK;
  logic        Enable;
  logic [15:0] Value;
  logic [3:0]  DP;
  logic [3:0]  an1, an3;
  logic [6:0]  seg1, seg3;
  logic        dp1, dp3;

  always #5 CLK = ~CLK;

  display_scan_7seg #(.DWELL_TICKS(1)) dut (
    .CLK(CLK), .Reset(Reset), .DivCLK(DivCLK), .Enable(Enable), .Value(Value), .DP(DP),
    .Anodes(an1), .Segments(seg1), .DPout(dp1)
  );

  display_scan_7seg #(.DWELL_TICKS(3)) dut3 (
    .CLK(CLK), .Reset(Reset), .DivCLK(DivCLK), .Enable(Enable), .Value(Value), .DP(DP),
    .Anodes(an3), .Segments(seg3), .DPout(dp3)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: count of enabled DivCLK rising edges within the current sweep, plus the captured sample.
  int unsigned m_d [2] = '{1, 3};
  int unsigned m_n [2];
  logic [15:0] m_sv [2];
  logic [3:0]  m_sdp [2];
  logic        m_en;

  typedef struct {
    logic        pulse;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [11:0] model_exp(int k);
    logic [1:0]  idx;
    logic [15:0] hi;
    logic [11:0] r;
    if (!m_en) return 12'hFFF;
    idx      = 2'((m_n[k] / m_d[k]) % 4);
    hi       = m_sv[k] >> {idx, 2'b00};
    r[11:8]  = 4'hF ^ (4'b0001 << idx);
    r[7:1]   = glyph[hi[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != 2'd0 && hi == 16'h0000) r[7:1] = 7'h7F;
`endif
    r[0]     = ~m_sdp[k][idx];
    return r;
  endfunction

  function automatic logic [11:0] got(int k);
    return (k == 0) ? {an1, seg1, dp1} : {an3, seg3, dp3};
  endfunction

  task automatic chk(input string name, input logic [11:0] g, input logic [11:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, g[11:8], g[7:1], g[0], e[11:8], e[7:1], e[0]);
    end
  endtask

  task automatic chk_model(input string name);
    chk({name, "/d1"}, got(0), model_exp(0));
    chk({name, "/d3"}, got(1), model_exp(1));
  endtask

  task automatic m_snap(input int k);
    m_sv[k]  = Value;
    m_sdp[k] = DP;
  endtask

  task automatic m_tick();
    if (m_en) begin
      for (int k = 0; k < 2; k++) begin
        m_n[k] = (m_n[k] + 1) % (4 * m_d[k]);
        if (m_n[k] == 0) m_snap(k);
      end
    end
  endtask

  task automatic wait_neg(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse();
    @(negedge CLK);
    DivCLK = 1'b1;
    m_tick();
    wait_neg(6);
    DivCLK = 1'b0;
    wait_neg(6);
  endtask

  task automatic set_en(input logic b);
    @(negedge CLK);
    Enable = b;
    if (b && !m_en) begin m_snap(0); m_snap(1); end
    m_en = b;
    wait_neg(4);
  endtask

  task automatic set_val(input logic [15:0] v, input logic [3:0] d);
    @(negedge CLK);
    Value = v;
    DP    = d;
    wait_neg(1);
  endtask

  task automatic do_reset(input logic en, input logic [15:0] v, input logic [3:0] d);
    @(posedge CLK);
    #2;
    Reset  = 1'b0;
    Value  = 16'($urandom);
    DP     = 4'($urandom);
    Enable = 1'($urandom);
    #1;
    chk("reset_async/d1", got(0), 12'hFFF);
    chk("reset_async/d3", got(1), 12'hFFF);
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_sv[k] = '0; m_sdp[k] = '0;
    end
    m_en = 1'b0;
    wait_neg(3);
    chk("reset_hold/d1", got(0), 12'hFFF);
    Value  = v;
    DP     = d;
    Enable = en;
    Reset  = 1'b1;
    if (en) begin m_snap(0); m_snap(1); m_en = 1'b1; end
    wait_neg(4);
  endtask

  initial begin
    logic [11:0] pre;
    logic [15:0] rv;
    logic [6:0]  lz_seg [4];

    Reset = 1'b0; DivCLK = 1'b0; Enable = 1'b0; Value = '0; DP = '0;
    for (int k = 0; k < 2; k++) begin m_n[k] = 0; m_sv[k] = '0; m_sdp[k] = '0; end
    m_en = 1'b0;

    tbl[0]  = '{1'b0, 16'h1234, 4'b0100, 4'b1110, 7'h19, 1'b1};
    tbl[1]  = '{1'b1, 16'h1234, 4'b0100, 4'b1101, 7'h30, 1'b1};
    tbl[2]  = '{1'b1, 16'h1234, 4'b0100, 4'b1011, 7'h24, 1'b0};
    tbl[3]  = '{1'b1, 16'h1234, 4'b0100, 4'b0111, 7'h79, 1'b1};
    tbl[4]  = '{1'b1, 16'h1234, 4'b0100, 4'b1110, 7'h19, 1'b1};
    tbl[5]  = '{1'b1, 16'h1234, 4'b0100, 4'b1101, 7'h30, 1'b1};
    tbl[6]  = '{1'b0, 16'hABCD, 4'b0100, 4'b1101, 7'h30, 1'b1};
    tbl[7]  = '{1'b1, 16'hABCD, 4'b0100, 4'b1011, 7'h24, 1'b0};
    tbl[8]  = '{1'b1, 16'hABCD, 4'b0100, 4'b0111, 7'h79, 1'b1};
    tbl[9]  = '{1'b1, 16'hABCD, 4'b0100, 4'b1110, 7'h21, 1'b1};
    tbl[10] = '{1'b1, 16'hABCD, 4'b0100, 4'b1101, 7'h46, 1'b1};
    tbl[11] = '{1'b1, 16'hABCD, 4'b0100, 4'b1011, 7'h03, 1'b0};
    tbl[12] = '{1'b1, 16'hABCD, 4'b0100, 4'b0111, 7'h08, 1'b1};

    do_reset(1'b1, 16'h1234, 4'b0100);

    for (int unsigned i = 0; i < 13; i++) begin
      set_val(tbl[i].val, tbl[i].dp);
      if (tbl[i].pulse) pulse(); else wait_neg(2);
      chk($sformatf("tbl%0d", i), got(0), {tbl[i].an, tbl[i].seg, tbl[i].dpo});
      chk($sformatf("tbl%0d/d3", i), got(1), model_exp(1));
    end

    // Exact latency: outputs must change on the third edge after DivCLK is first sampled high.
    pre = model_exp(0);
    @(negedge CLK);
    DivCLK = 1'b1;
    m_tick();
    @(posedge CLK); #1;
    chk("lat_k0", got(0), pre);
    for (int unsigned j = 1; j < 3; j++) begin
      @(posedge CLK); #1;
      chk($sformatf("lat_k%0d", j), got(0), pre);
    end
    @(posedge CLK); #1;
    chk("lat_k3", got(0), model_exp(0));
    chk("lat_k3_an", {an1, 8'h00}, {4'b1110, 8'h00});
    wait_neg(4);
    DivCLK = 1'b0;
    wait_neg(6);

    // Enable low for 10 ticks while digit 2 is lit.
    pulse();
    pulse();
    chk("pre_dis_an", {an1, 8'h00}, {4'b1011, 8'h00});
    @(negedge CLK);
    Enable = 1'b0;
    m_en   = 1'b0;
    @(posedge CLK); #1;
    chk("en_fall/d1", got(0), 12'hFFF);
    chk("en_fall/d3", got(1), 12'hFFF);
    for (int unsigned j = 0; j < 10; j++) pulse();
    chk_model("en_low");
    set_en(1'b1);
    chk_model("reen");
    chk("reen_an", {an1, 8'h00}, {4'b1011, 8'h00});
    pulse();
    chk_model("reen_adv");
    chk("reen_adv_an", {an1, 8'h00}, {4'b0111, 8'h00});

    // Dwell of 3: each digit holds for exactly three DivCLK rising edges.
    do_reset(1'b1, 16'h5678, 4'b0001);
    chk_model("dw3_start");
    for (int unsigned i = 0; i < 12; i++) begin
      pulse();
      chk($sformatf("dw3_an%0d", i), {an3, 8'h00},
          {4'hF ^ (4'b0001 << (((i + 1) / 3) % 4)), 8'h00});
    end

    // Leading-zero handling for 16'h0070.
    lz_seg[0] = 7'h40;
    lz_seg[1] = 7'h78;
`ifdef LEADING_ZERO_BLANK_EN
    lz_seg[2] = 7'h7F;
    lz_seg[3] = 7'h7F;
`else
    lz_seg[2] = 7'h40;
    lz_seg[3] = 7'h40;
`endif
    do_reset(1'b1, 16'h0070, 4'b0000);
    for (int unsigned i = 0; i < 4; i++) begin
      chk($sformatf("lz%0d", i), got(0), {4'hF ^ (4'b0001 << i), lz_seg[i], 1'b1});
      pulse();
    end

    // Randomised operation mix against the model.
    for (int unsigned s = 0; s < 200; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: pulse();
        6, 7: begin
          rv = 16'($urandom);
          case ($urandom_range(0, 3))
            0: rv = rv & 16'h00FF;
            1: rv = rv & 16'h000F;
            2: rv = rv & 16'h0F0F;
            default: ;
          endcase
          set_val(rv, 4'($urandom));
        end
        8: set_en(~Enable);
        default: wait_neg(3);
      endcase
      chk_model($sformatf("rnd%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
